// File: rtl/chess_board_engine.sv
// Board-state engine: owns the flattened board, a key-driven cursor, and a lock/validate/commit
// move FSM with one-square-per-cycle path scanning for sliding pieces.
module chess_board_engine #(
  parameter int BOARD_SIZE   = 8,
  parameter int SQUARE_WIDTH = 8,
  parameter int START_X      = 2,
  parameter int START_Y      = 3,
  parameter int MATRIX_WIDTH = BOARD_SIZE*BOARD_SIZE*SQUARE_WIDTH
) (
  input  logic                    OutClock,
  input  logic                    resetApp,
  input  logic                    KeyLeft,
  input  logic                    KeyRight,
  input  logic                    KeyUp,
  input  logic                    KeyDown,
  input  logic                    LockSwitch,
  output logic [MATRIX_WIDTH-1:0] Layout,
  output logic                    Player,
  output logic                    MoveDone,
  output logic                    MoveReject
);
  localparam int CW  = $clog2(BOARD_SIZE);
  localparam int DW  = CW + 1;
  localparam int IW  = 2*CW;
  localparam int NSQ = BOARD_SIZE*BOARD_SIZE;
  localparam int SW  = SQUARE_WIDTH;
  localparam int LW  = $clog2(MATRIX_WIDTH);

  typedef logic [CW-1:0]        coord_t;
  typedef logic signed [DW-1:0] diff_t;
  typedef enum logic [1:0] {IDLE, LOCKED, CHECK, COMMIT} state_t;

  function automatic logic [LW-1:0] pos(logic [IW-1:0] idx, int b);
    return LW'(int'(idx)*SW + b);
  endfunction

  function automatic logic [2:0] backRank(int x);
    case (x)
      0, 7:    return 3'd3;
      1, 6:    return 3'd2;
      2, 5:    return 3'd4;
      3:       return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  function automatic logic [MATRIX_WIDTH-1:0] initLayout();
    logic [MATRIX_WIDTH-1:0] r;
    r = '0;
    for (int x = 0; x < BOARD_SIZE; x++) begin
      r[pos(IW'(x), 0) +: 4]                                = {1'b0, backRank(x)};
      r[pos(IW'(BOARD_SIZE+x), 0) +: 4]                     = 4'h1;
      r[pos(IW'((BOARD_SIZE-2)*BOARD_SIZE+x), 0) +: 4]      = 4'h9;
      r[pos(IW'((BOARD_SIZE-1)*BOARD_SIZE+x), 0) +: 4]      = {1'b1, backRank(x)};
    end
    r[pos(IW'(START_Y*BOARD_SIZE+START_X), 4)] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] pcAt(logic [MATRIX_WIDTH-1:0] l, logic [IW-1:0] idx);
    return l[pos(idx, 0) +: 4];
  endfunction

  function automatic logic isEmpty(logic [MATRIX_WIDTH-1:0] l, logic [IW-1:0] idx);
    return l[pos(idx, 0) +: 3] == 3'd0;
  endfunction

  state_t state;
  logic   scanning;
  coord_t curX, curY, srcX, srcY, dstX, dstY, scanX, scanY;
  coord_t curXN, curYN, stepX, stepY, firstX, firstY, nextX, nextY, midY, homeY, farY;
  logic [IW-1:0] curIdx, curIdxN, srcIdx, dstIdx, firstIdx, nextIdx;
  logic [3:0] curPc, srcPc, dstPc;
  diff_t dx, dy, adx, ady, fwd;
  logic white, sliding, geomOk, lockOk, checkPass, checkFail, dstEmpty;

  // Keys are active-low; wrap is free because BOARD_SIZE is a power of two.
  always_comb begin
    curXN = curX;
    curYN = curY;
    if (state == IDLE || state == LOCKED) begin
      if      (!KeyLeft)  curXN = curX - coord_t'(1);
      else if (!KeyRight) curXN = curX + coord_t'(1);
      else if (!KeyUp)    curYN = curY - coord_t'(1);
      else if (!KeyDown)  curYN = curY + coord_t'(1);
    end
  end

  assign curIdx   = {curY, curX};
  assign curIdxN  = {curYN, curXN};
  assign srcIdx   = {srcY, srcX};
  assign dstIdx   = {dstY, dstX};
  assign curPc    = pcAt(Layout, curIdx);
  assign srcPc    = pcAt(Layout, srcIdx);
  assign dstPc    = pcAt(Layout, dstIdx);
  assign lockOk   = LockSwitch && curPc[2:0] != 3'd0 && curPc[3] == Player;

  assign white    = srcPc[3];
  assign dstEmpty = dstPc[2:0] == 3'd0;
  assign dx       = $signed({1'b0, dstX}) - $signed({1'b0, srcX});
  assign dy       = $signed({1'b0, dstY}) - $signed({1'b0, srcY});
  assign adx      = dx[DW-1] ? -dx : dx;
  assign ady      = dy[DW-1] ? -dy : dy;
  assign fwd      = white ? diff_t'(-1) : diff_t'(1);
  assign midY     = white ? srcY - coord_t'(1) : srcY + coord_t'(1);
  assign homeY    = white ? coord_t'(BOARD_SIZE-2) : coord_t'(1);
  assign farY     = white ? coord_t'(0) : coord_t'(BOARD_SIZE-1);
  assign sliding  = srcPc[2:0] == 3'd3 || srcPc[2:0] == 3'd4 || srcPc[2:0] == 3'd5;

  assign stepX    = (dx == 0) ? coord_t'(0) : (dx[DW-1] ? '1 : coord_t'(1));
  assign stepY    = (dy == 0) ? coord_t'(0) : (dy[DW-1] ? '1 : coord_t'(1));
  assign firstX   = srcX + stepX;
  assign firstY   = srcY + stepY;
  assign nextX    = scanX + stepX;
  assign nextY    = scanY + stepY;
  assign firstIdx = {firstY, firstX};
  assign nextIdx  = {nextY, nextX};

  always_comb begin
    geomOk = 1'b0;
    if (srcIdx != dstIdx && !(!dstEmpty && dstPc[3] == white)) begin
      case (srcPc[2:0])
        3'd1: geomOk = (dx == 0 && dy == fwd && dstEmpty) ||
                       (dx == 0 && dy == fwd + fwd && srcY == homeY && dstEmpty &&
                        isEmpty(Layout, {midY, srcX})) ||
                       (adx == 1 && dy == fwd && !dstEmpty);
        3'd2: geomOk = (adx == 1 && ady == 2) || (adx == 2 && ady == 1);
        3'd3: geomOk = dx == 0 || dy == 0;
        3'd4: geomOk = adx == ady;
        3'd5: geomOk = dx == 0 || dy == 0 || adx == ady;
        3'd6: geomOk = adx <= 1 && ady <= 1;
        default: geomOk = 1'b0;
      endcase
    end
  end

  // First CHECK cycle does geometry; later cycles examine one intermediate square each.
  always_comb begin
    checkPass = 1'b0;
    checkFail = 1'b0;
    if (!scanning) begin
      if (!geomOk)                           checkFail = 1'b1;
      else if (!sliding || firstIdx == dstIdx) checkPass = 1'b1;
    end else if (!isEmpty(Layout, {scanY, scanX})) begin
      checkFail = 1'b1;
    end else if (nextIdx == dstIdx) begin
      checkPass = 1'b1;
    end
  end

  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      Layout     <= initLayout();
      state      <= IDLE;
      scanning   <= 1'b0;
      Player     <= 1'b1;
      MoveDone   <= 1'b0;
      MoveReject <= 1'b0;
      curX       <= coord_t'(START_X);
      curY       <= coord_t'(START_Y);
      srcX <= '0; srcY <= '0; dstX <= '0; dstY <= '0; scanX <= '0; scanY <= '0;
    end else begin
      MoveDone   <= 1'b0;
      MoveReject <= 1'b0;
      curX       <= curXN;
      curY       <= curYN;
      for (int i = 0; i < NSQ; i++) Layout[pos(IW'(i), 4)] <= (curIdxN == IW'(i));
      case (state)
        IDLE: if (lockOk) begin
          srcX <= curX;
          srcY <= curY;
          Layout[pos(curIdx, 5)]  <= 1'b1;
          Layout[pos(curIdxN, 6)] <= 1'b1;
          state <= LOCKED;
        end
        LOCKED: begin
          for (int i = 0; i < NSQ; i++) Layout[pos(IW'(i), 6)] <= (curIdxN == IW'(i));
          if (!LockSwitch) begin
            dstX     <= curX;
            dstY     <= curY;
            scanning <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (checkPass || checkFail) begin
            for (int i = 0; i < NSQ; i++) begin
              Layout[pos(IW'(i), 5)] <= 1'b0;
              Layout[pos(IW'(i), 6)] <= 1'b0;
            end
            scanning   <= 1'b0;
            MoveReject <= checkFail;
            state      <= checkPass ? COMMIT : IDLE;
          end else begin
            scanX    <= scanning ? nextX : firstX;
            scanY    <= scanning ? nextY : firstY;
            scanning <= 1'b1;
          end
        end
        COMMIT: begin
          Layout[pos(dstIdx, 0) +: 4] <= (srcPc[2:0] == 3'd1 && dstY == farY) ?
                                         {srcPc[3], 3'd5} : srcPc;
          Layout[pos(srcIdx, 0) +: 4] <= 4'h0;
          MoveDone <= 1'b1;
          Player   <= ~Player;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chess_board_engine.sv
// Directed bench for chess_board_engine: reset layout, cursor wrap, locking, and timed
// accept/reject of pawn, rook, bishop, knight, king moves plus a reset during a queen scan.
module tb_chess_board_engine;
  localparam int N  = 8;
  localparam int SW = 8;
  localparam int MW = N*N*SW;
  localparam int K_L = 0, K_R = 1, K_U = 2, K_D = 3;

  logic OutClock = 1'b0;
  logic resetApp, KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch;
  logic [MW-1:0] Layout;
  logic Player, MoveDone, MoveReject;

  int nVec = 0, nBad = 0;
  int cx = 2, cy = 3;
  logic [3:0] mdl [N*N];

  always #5 OutClock = ~OutClock;

  chess_board_engine dut (
    .OutClock(OutClock), .resetApp(resetApp),
    .KeyLeft(KeyLeft), .KeyRight(KeyRight), .KeyUp(KeyUp), .KeyDown(KeyDown),
    .LockSwitch(LockSwitch), .Layout(Layout), .Player(Player),
    .MoveDone(MoveDone), .MoveReject(MoveReject)
  );

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sq(int x, int y);
    return Layout[9'((y*N+x)*SW) +: SW];
  endfunction

  function automatic logic [MW-1:0] expLayout();
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < N*N; i++) r[9'(i*SW) +: 4] = mdl[i];
    r[9'((cy*N+cx)*SW+4)] = 1'b1;
    return r;
  endfunction

  task automatic initModel();
    int back [8] = '{3, 2, 4, 5, 6, 4, 2, 3};
    for (int i = 0; i < N*N; i++) mdl[i] = 4'h0;
    for (int x = 0; x < N; x++) begin
      mdl[x]       = 4'(back[x]);
      mdl[N+x]     = 4'h1;
      mdl[6*N+x]   = 4'h9;
      mdl[7*N+x]   = 4'(8 + back[x]);
    end
    cx = 2; cy = 3;
  endtask

  task automatic step();
    @(posedge OutClock);
    #1;
  endtask

  task automatic press(input int k);
    case (k)
      K_L: KeyLeft = 1'b0;
      K_R: KeyRight = 1'b0;
      K_U: KeyUp = 1'b0;
      default: KeyDown = 1'b0;
    endcase
    step();
    KeyLeft = 1'b1; KeyRight = 1'b1; KeyUp = 1'b1; KeyDown = 1'b1;
  endtask

  task automatic moveTo(input int tx, input int ty);
    while (cx != tx) begin
      if (tx < cx) begin press(K_L); cx--; end
      else begin press(K_R); cx++; end
    end
    while (cy != ty) begin
      if (ty < cy) begin press(K_U); cy--; end
      else begin press(K_D); cy++; end
    end
  endtask

  // lat = edges after the release edge until the result pulse is visible
  task automatic doMove(input string tag, input int sx, input int sy, input int tx, input int ty,
                        input bit accept, input int lat);
    moveTo(sx, sy);
    LockSwitch = 1'b1;
    step();
    chk({tag, " lock"}, sq(sx, sy), {4'b0111, mdl[sy*N+sx]});
    moveTo(tx, ty);
    LockSwitch = 1'b0;
    step();
    for (int i = 1; i < lat; i++) begin
      step();
      chk({tag, " early"}, {MoveDone, MoveReject}, 2'b00);
    end
    step();
    if (accept) begin
      mdl[ty*N+tx] = mdl[sy*N+sx];
      mdl[sy*N+sx] = 4'h0;
    end
    chk({tag, " pulse"}, {MoveDone, MoveReject}, accept ? 2'b10 : 2'b01);
    chk({tag, " board"}, Layout, expLayout());
    step();
    chk({tag, " once"}, {MoveDone, MoveReject}, 2'b00);
  endtask

  initial begin
    resetApp = 1'b1;
    KeyLeft = 1'b1; KeyRight = 1'b1; KeyUp = 1'b1; KeyDown = 1'b1;
    LockSwitch = 1'b0;
    initModel();
    #12;
    chk("reset layout", Layout, expLayout());
    chk("reset player", Player, 1'b1);
    chk("reset pulses", {MoveDone, MoveReject}, 2'b00);
    #1 resetApp = 1'b0;
    step();
    chk("idle layout", Layout, expLayout());

    KeyLeft = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      cx = (i == 2) ? 7 : 1 - i;
      chk("wrap left", Layout, expLayout());
    end
    KeyLeft = 1'b1;
    chk("wrap player", Player, 1'b1);

    moveTo(0, 1);
    LockSwitch = 1'b1;
    repeat (3) step();
    chk("wrong side board", Layout, expLayout());
    chk("wrong side pulses", {MoveDone, MoveReject}, 2'b00);
    LockSwitch = 1'b0;
    step();

    doMove("pawn2", 4, 6, 4, 4, 1'b1, 2);
    chk("pawn2 player", Player, 1'b0);
    doMove("bpawn", 0, 1, 0, 2, 1'b1, 2);
    chk("bpawn player", Player, 1'b1);
    doMove("rook blocked", 0, 7, 0, 5, 1'b0, 2);
    chk("rook player", Player, 1'b1);
    doMove("bishop", 5, 7, 2, 4, 1'b1, 4);
    chk("bishop player", Player, 1'b0);
    doMove("bknight", 1, 0, 2, 2, 1'b1, 2);
    doMove("king2", 4, 7, 4, 5, 1'b0, 1);
    chk("king player", Player, 1'b1);
    doMove("wknight", 6, 7, 5, 5, 1'b1, 2);
    chk("wknight player", Player, 1'b0);

    moveTo(3, 0);
    LockSwitch = 1'b1;
    step();
    chk("queen lock", sq(3, 0), 8'h75);
    moveTo(3, 3);
    LockSwitch = 1'b0;
    step();
    step();
    #2 resetApp = 1'b1;
    #1;
    initModel();
    chk("midscan layout", Layout, expLayout());
    chk("midscan player", Player, 1'b1);
    chk("midscan pulses", {MoveDone, MoveReject}, 2'b00);
    #1 resetApp = 1'b0;
    step();
    chk("post reset layout", Layout, expLayout());
    chk("post reset pulses", {MoveDone, MoveReject}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
